pool_engine: RTL and testbench
==============================

// Module: pool_engine
// PURPOSE
//  Parametrised 2-D pooling engine for the CNN datapath; successor to the fixed 2x2 max pooler.
//  Loads a 4-word descriptor from DRAM, then scans a DEPTH x HEIGHT x WIDTH ifmap in KxK
//  non-overlapping windows (stride K). Writes one max or average result per window to the ofmap region.
//  Shares the single-port DRAM read/write interface with the other layer engines; started by the layer sequencer.
// PARAMETERS
//  DATA_WIDTH  32      pixel width, signed two's complement
//  ADDR_WIDTH  18      DRAM word address width
//  DIM_WIDTH   5       bits per x/y/z address field; max dimension 2**DIM_WIDTH
//  PARAM_BASE  0       descriptor base address
//  OFMAP_BASE  65536   output feature map base address
//  IFMAP_BASE  131072  input feature map base address
// PORTS
//  clk         in   1           clock
//  srstn       in   1           reset, synchronous, active-low
//  enable      in   1           start pulse; sampled only in IDLE
//  dram_valid  in   1           read ack: data_in valid for addr_in this cycle
//  data_in     in   DATA_WIDTH  DRAM read data
//  data_out    out  DATA_WIDTH  pooled result, registered
//  addr_in     out  ADDR_WIDTH  DRAM read address
//  addr_out    out  ADDR_WIDTH  DRAM write address, registered
//  dram_en_rd  out  1           read request
//  dram_en_wr  out  1           write strobe; 1-cycle pulse, always accepted
//  done        out  1           1-cycle pulse at end of layer
// BEHAVIOUR
//  Reset: state IDLE; data_out, addr_out, addr_in = 0; dram_en_rd, dram_en_wr, done = 0; all counters = 0.
//  Reset mid-operation aborts at once: no pending write issues after srstn is released.
//  Read handshake:
//   - dram_en_rd is held with a stable addr_in until dram_valid=1.
//   - The read is accepted when dram_en_rd & dram_valid; data_in is consumed and counters advance that cycle.
//  FSM: IDLE -enable-> LD_PARAM -4th word accepted-> CHECK -> POOL -last write-> DONE -> IDLE.
//   - LD_PARAM reads PARAM_BASE+0..3: width, height, depth (data_in[DIM_WIDTH:0] each), mode word.
//   - mode[0]: 0 = max, 1 = avg. mode[1]: 0 gives K=2, 1 gives K=4.
//   - CHECK (1 cycle): if width<K, height<K, or depth=0, go straight to DONE with zero writes.
//  Scan order: z outer, window-y, window-x, then dy, dx raster inside the window.
//   - Window bases: x,y in steps of K while base+K <= dim. Trailing partial rows/cols are dropped (floor).
//  addr_in  = IFMAP_BASE + {z, y+dy, x+dx}, each field DIM_WIDTH bits.
//  addr_out = OFMAP_BASE + {z, y/K, x/K}, each field DIM_WIDTH bits.
//  Accumulator, DATA_WIDTH+4 bits:
//   - The first accepted pixel of a window loads it.
//   - Later pixels: max mode does a signed compare, keeping the larger value (ties keep the current value).
//     Avg mode adds the sign-extended pixel.
//  Result: avg = sum >>> (2*log2 K), arithmetic shift (floor), truncated to DATA_WIDTH. Max is exact.
//  Latency: data_out, addr_out and the dram_en_wr pulse come 1 cycle after the window's last pixel is accepted.
//  Reads of the next window continue in parallel, so there are no bubbles when dram_valid stays high.
//  A write and the next read may be active in the same cycle.
//  After the final write pulse, FSM enters DONE. done=1 for exactly 1 cycle, then IDLE.
//  enable outside IDLE is ignored. dram_en_rd=0 in IDLE, CHECK and DONE.
//  dram_valid while dram_en_rd=0 is ignored.
// CONFIGURATION
//  POOL_AVG_EN defined: avg mode is available as above.
//  POOL_AVG_EN undefined: mode[0] is ignored and max is always used. The adder and shifter are not built.
//  Without POOL_AVG_EN the accumulator is DATA_WIDTH bits.
// TESTING
//  1. 4x4x1, K=2 max, dram_valid=1, pixels 0..15 raster:
//     writes 5,7,13,15 to OFMAP_BASE+{0,0,0},{0,0,1},{0,1,0},{0,1,1}; done 1 cycle later.
//  2. Same ifmap, all pixels -3, avg (POOL_AVG_EN): four writes of -3.
//     Pixels {-1,0,0,0} avg gives -1 (floor rounding).
//  3. 5x5x2, K=2, max: 4 writes per channel, 8 total. Row/col 4 is never read. z field increments.
//  4. dram_valid toggling 1-of-3 cycles on case 1: addr_in is held while unacked; results identical.
//  5. width=1 descriptor: after CHECK, goes straight to DONE. No write occurs and done pulses once.
//  6. srstn low during POOL, then enable re-issued:
//     all outputs 0 during reset; the rerun of case 1 gives identical results.

Source files
------------

// File: rtl/pool_engine.sv
// Parametrised KxK (K=2/4) max/avg pooling engine with descriptor load over a shared DRAM port.
// Optional average mode is built only when POOL_AVG_EN is defined; otherwise max pooling only.
module pool_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int DIM_WIDTH  = 5,
  parameter int PARAM_BASE = 0,
  parameter int OFMAP_BASE = 65536,
  parameter int IFMAP_BASE = 131072
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LD_PARAM = 3'd1;
  localparam logic [2:0] CHECK    = 3'd2;
  localparam logic [2:0] POOL     = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam int CW = DIM_WIDTH + 3;
`ifdef POOL_AVG_EN
  localparam int ACC_W = DATA_WIDTH + 4;
`else
  localparam int ACC_W = DATA_WIDTH;
`endif

  logic [2:0]             state;
  logic [DIM_WIDTH:0]     width, height, depth, z;
  logic                   k4;
`ifdef POOL_AVG_EN
  logic                   avg_mode;
`endif
  logic [1:0]             pcnt, dx, dy, kmax;
  logic [CW-1:0]          wx, wy, kk;
  logic                   rd_done, rd_acc, first, last;
  logic [DIM_WIDTH-1:0]   xx, yy, ox, oy;
  logic signed [ACC_W-1:0] acc, pix, comb;
  logic [DATA_WIDTH-1:0]  result;

  always_comb begin
    kk         = k4 ? CW'(4) : CW'(2);
    kmax       = k4 ? 2'd3 : 2'd1;
    dram_en_rd = (state == LD_PARAM) || ((state == POOL) && !rd_done);
    rd_acc     = dram_en_rd && dram_valid;
    done       = (state == DONE);
    xx         = DIM_WIDTH'(wx + CW'(dx));
    yy         = DIM_WIDTH'(wy + CW'(dy));
    ox         = DIM_WIDTH'(k4 ? (wx >> 2) : (wx >> 1));
    oy         = DIM_WIDTH'(k4 ? (wy >> 2) : (wy >> 1));
    addr_in    = '0;
    if (state == LD_PARAM)
      addr_in = ADDR_WIDTH'(PARAM_BASE) + ADDR_WIDTH'(pcnt);
    else if (state == POOL)
      addr_in = ADDR_WIDTH'(IFMAP_BASE) + ADDR_WIDTH'({z[DIM_WIDTH-1:0], yy, xx});
    first = (dx == 2'd0) && (dy == 2'd0);
    last  = (dx == kmax) && (dy == kmax);
    pix   = $signed(data_in);
    // comb is the window value including the pixel accepted this cycle, so the
    // result can be registered without waiting for acc to update.
    if (first)
      comb = pix;
`ifdef POOL_AVG_EN
    else if (avg_mode)
      comb = acc + pix;
`endif
    else
      comb = (pix > acc) ? pix : acc;
`ifdef POOL_AVG_EN
    if (avg_mode)
      result = DATA_WIDTH'(k4 ? (comb >>> 4) : (comb >>> 2));
    else
      result = DATA_WIDTH'(comb);
`else
    result = DATA_WIDTH'(comb);
`endif
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state      <= IDLE;
      data_out   <= '0;
      addr_out   <= '0;
      dram_en_wr <= 1'b0;
      width      <= '0;
      height     <= '0;
      depth      <= '0;
      k4         <= 1'b0;
`ifdef POOL_AVG_EN
      avg_mode   <= 1'b0;
`endif
      pcnt       <= '0;
      dx         <= '0;
      dy         <= '0;
      wx         <= '0;
      wy         <= '0;
      z          <= '0;
      rd_done    <= 1'b0;
      acc        <= '0;
    end else begin
      dram_en_wr <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          state   <= LD_PARAM;
          pcnt    <= '0;
          dx      <= '0;
          dy      <= '0;
          wx      <= '0;
          wy      <= '0;
          z       <= '0;
          rd_done <= 1'b0;
        end
        LD_PARAM: if (rd_acc) begin
          case (pcnt)
            2'd0: width  <= data_in[DIM_WIDTH:0];
            2'd1: height <= data_in[DIM_WIDTH:0];
            2'd2: depth  <= data_in[DIM_WIDTH:0];
            default: begin
              k4 <= data_in[1];
`ifdef POOL_AVG_EN
              avg_mode <= data_in[0];
`endif
            end
          endcase
          pcnt <= pcnt + 2'd1;
          if (pcnt == 2'd3) state <= CHECK;
        end
        CHECK: begin
          if ((CW'(width) < kk) || (CW'(height) < kk) || (depth == '0))
            state <= DONE;
          else
            state <= POOL;
        end
        POOL: begin
          // rd_done rises with the final write; it is visible one cycle later.
          if (rd_done) begin
            state <= DONE;
          end else if (rd_acc) begin
            acc <= comb;
            if (last) begin
              data_out   <= result;
              addr_out   <= ADDR_WIDTH'(OFMAP_BASE) + ADDR_WIDTH'({z[DIM_WIDTH-1:0], oy, ox});
              dram_en_wr <= 1'b1;
            end
            if (dx != kmax) begin
              dx <= dx + 2'd1;
            end else begin
              dx <= '0;
              if (dy != kmax) begin
                dy <= dy + 2'd1;
              end else begin
                dy <= '0;
                if (wx + kk + kk <= CW'(width)) begin
                  wx <= wx + kk;
                end else begin
                  wx <= '0;
                  if (wy + kk + kk <= CW'(height)) begin
                    wy <= wy + kk;
                  end else begin
                    wy <= '0;
                    if (z + 1'b1 == depth) rd_done <= 1'b1;
                    else z <= z + 1'b1;
                  end
                end
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_engine.sv
// Directed self-checking bench for pool_engine: DRAM read model, write capture, expected-value tables.
module tb_pool_engine;
  localparam int OFB = 65536;
  localparam int IFB = 131072;

  logic        clk = 1'b0;
  logic        srstn = 1'b0;
  logic        enable = 1'b0;
  logic        dram_valid = 1'b0;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [17:0] addr_in, addr_out;
  logic        dram_en_rd, dram_en_wr, done;

  pool_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(18), .DIM_WIDTH(5),
                .PARAM_BASE(0), .OFMAP_BASE(OFB), .IFMAP_BASE(IFB)) dut (
    .clk(clk), .srstn(srstn), .enable(enable), .dram_valid(dram_valid),
    .data_in(data_in), .data_out(data_out), .addr_in(addr_in), .addr_out(addr_out),
    .dram_en_rd(dram_en_rd), .dram_en_wr(dram_en_wr), .done(done));

  always #5 clk = ~clk;

  logic [31:0] desc [0:3];
  logic [31:0] ifm  [0:32767];

  always_comb begin
    data_in = '0;
    if (addr_in < 18'd4) data_in = desc[addr_in[1:0]];
    else if (addr_in >= 18'(IFB)) data_in = ifm[addr_in[14:0]];
  end

  int vmode = 0;
  int vcnt = 0;
  initial forever begin
    @(posedge clk);
    #2;
    vcnt++;
    dram_valid = (vmode == 0) ? 1'b1 : ((vcnt % 3) == 0);
  end

  logic [17:0] wq_a[$], ex_a[$];
  logic [31:0] wq_d[$], ex_d[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0, hold_err = 0;
  int max_x = 0, max_y = 0;
  logic        prev_pend = 1'b0;
  logic [17:0] prev_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (dram_en_wr) begin
      wq_a.push_back(addr_out);
      wq_d.push_back(data_out);
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (dram_en_rd && dram_valid && addr_in >= 18'(IFB)) begin
      if (int'(addr_in[4:0]) > max_x) max_x = int'(addr_in[4:0]);
      if (int'(addr_in[9:5]) > max_y) max_y = int'(addr_in[9:5]);
    end
    if (prev_pend && dram_en_rd && addr_in != prev_addr) hold_err++;
    prev_pend = dram_en_rd && !dram_valid;
    prev_addr = addr_in;
  end

  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input int z, input int y, input int x);
    return (z << 10) | (y << 5) | x;
  endfunction

  task automatic clear_ifm();
    for (int unsigned i = 0; i < 32768; i++) ifm[i] = '0;
  endtask

  task automatic expect_w(input int a, input logic [31:0] d);
    ex_a.push_back(18'(OFB + a));
    ex_d.push_back(d);
  endtask

  task automatic run_layer(input int w, input int h, input int d, input int mode, input int vm);
    desc[0] = w; desc[1] = h; desc[2] = d; desc[3] = mode;
    wq_a.delete(); wq_d.delete();
    done_cnt = 0; hold_err = 0; max_x = 0; max_y = 0;
    vmode = vm;
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    for (int i = 0; i < 5000 && done_cnt == 0; i++) @(posedge clk);
    if (done_cnt == 0) check("timeout_done", 64'(done_cnt), 64'(1));
    repeat (4) @(posedge clk);
  endtask

  task automatic verify(input string name);
    int n;
    check({name, "_nwr"}, 64'(wq_a.size()), 64'(ex_a.size()));
    n = (wq_a.size() < ex_a.size()) ? wq_a.size() : ex_a.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", name, i), 64'(wq_a[i]), 64'(ex_a[i]));
      check($sformatf("%s_data%0d", name, i), 64'(wq_d[i]), 64'(ex_d[i]));
    end
    check({name, "_done_cnt"}, 64'(done_cnt), 64'(1));
    if (ex_a.size() > 0)
      check({name, "_done_lat"}, 64'(done_cyc - last_wr_cyc), 64'(1));
    ex_a.delete(); ex_d.delete();
  endtask

  task automatic fill_raster4();
    clear_ifm();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) ifm[idx(0, y, x)] = 32'(y * 4 + x);
  endtask

  task automatic expect_case1();
    expect_w(idx(0, 0, 0), 32'd5);
    expect_w(idx(0, 0, 1), 32'd7);
    expect_w(idx(0, 1, 0), 32'd13);
    expect_w(idx(0, 1, 1), 32'd15);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_addr_out", 64'(addr_out), 64'(0));
    check("rst_addr_in", 64'(addr_in), 64'(0));
    check("rst_ctrl", 64'({dram_en_rd, dram_en_wr, done}), 64'(0));
    srstn = 1'b1;

    // 1: 4x4x1 K=2 max
    fill_raster4();
    expect_case1();
    run_layer(4, 4, 1, 0, 0);
    verify("c1");

    // 1b: K=4 max and avg on the same ifmap
    expect_w(0, 32'd15);
    run_layer(4, 4, 1, 2, 0);
    verify("k4max");
`ifdef POOL_AVG_EN
    expect_w(0, 32'd7);
`else
    expect_w(0, 32'd15);
`endif
    run_layer(4, 4, 1, 3, 0);
    verify("k4avg");

    // 2: all -3 in avg mode; max gives the same without the avg build
    clear_ifm();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) ifm[idx(0, y, x)] = -32'sd3;
    for (int i = 0; i < 4; i++) expect_w(idx(0, i / 2, i % 2), -32'sd3);
    run_layer(4, 4, 1, 1, 0);
    verify("c2");

    clear_ifm();
    ifm[idx(0, 0, 0)] = -32'sd1;
`ifdef POOL_AVG_EN
    expect_w(0, -32'sd1);
`else
    expect_w(0, 32'd0);
`endif
    run_layer(2, 2, 1, 1, 0);
    verify("c2floor");

    // 3: 5x5x2 K=2 max, trailing row/col dropped
    clear_ifm();
    for (int z = 0; z < 2; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++) ifm[idx(z, y, x)] = 32'(z * 100 + y * 5 + x);
    for (int z = 0; z < 2; z++)
      for (int wy = 0; wy < 4; wy += 2)
        for (int wx = 0; wx < 4; wx += 2)
          expect_w(idx(z, wy / 2, wx / 2), 32'(z * 100 + (wy + 1) * 5 + wx + 1));
    run_layer(5, 5, 2, 0, 0);
    verify("c3");
    check("c3_max_x", 64'(max_x), 64'(3));
    check("c3_max_y", 64'(max_y), 64'(3));

    // 4: throttled read acks
    fill_raster4();
    expect_case1();
    run_layer(4, 4, 1, 0, 1);
    verify("c4");
    check("c4_hold", 64'(hold_err), 64'(0));

    // 5: width below K
    expect_w(0, 32'd0);
    ex_a.delete(); ex_d.delete();
    run_layer(1, 4, 1, 0, 0);
    verify("c5");

    // 6: reset during POOL, then rerun case 1
    desc[0] = 4; desc[1] = 4; desc[2] = 1; desc[3] = 0;
    vmode = 1;
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    repeat (20) @(posedge clk);
    #1 srstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("c6_rst_data_out", 64'(data_out), 64'(0));
    check("c6_rst_addr_out", 64'(addr_out), 64'(0));
    check("c6_rst_addr_in", 64'(addr_in), 64'(0));
    check("c6_rst_ctrl", 64'({dram_en_rd, dram_en_wr, done}), 64'(0));
    wq_a.delete(); wq_d.delete(); done_cnt = 0;
    @(posedge clk); #1 srstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("c6_no_write", 64'(wq_a.size()), 64'(0));
    check("c6_no_done", 64'(done_cnt), 64'(0));
    expect_case1();
    run_layer(4, 4, 1, 0, 0);
    verify("c6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
